// File: rtl/mux_pipe_pkg.sv
// Shared types and constants for the N:1 pipelined selector and its skid buffer.
package mux_pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_t;

  localparam int MUX_N_MIN = 2;
  localparam int MUX_N_MAX = 16;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/mux_skid_buf.sv
// Two-entry skid buffer: registered in_ready, 1 item/cycle, state = number of held items.
module mux_skid_buf
  import mux_pipe_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] dout,
  output logic             out_valid,
  input  logic             out_ready
);

  state_t           state;
  logic [WIDTH-1:0] main;
  logic [WIDTH-1:0] skid;
  logic             accept;
  logic             emit;

  assign out_valid = (state != EMPTY);
  assign dout      = main;
  assign accept    = in_valid && in_ready;
  assign emit      = out_valid && out_ready;

  // in_ready is driven straight from a flop, so it is updated in every branch
  // that moves the FSM into or out of FULL.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the data registers are reset too, so dout reads 0 out of reset.
      state    <= EMPTY;
      main     <= '0;
      skid     <= '0;
      in_ready <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments only, so every branch sees pre-edge values.
      case (state)
        EMPTY: begin
          if (accept) begin
            main  <= in_data;
            state <= BUSY;
          end
        end
        BUSY: begin
          if (accept && !emit) begin
            skid     <= in_data;
            state    <= FULL;
            in_ready <= 1'b0;
          end else if (accept) begin
            main <= in_data;
          end else if (emit) begin
            state <= EMPTY;
          end
        end
        FULL: begin
          if (emit) begin
            main     <= skid;
            state    <= BUSY;
            in_ready <= 1'b1;
          end
        end
        default: begin
          state    <= EMPTY;
          in_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/mux_n_pipe.sv
// N:1 selector feeding a registered valid/ready output stage.
// Optional sticky out-of-range flag: define MUX_N_PIPE_SEL_ERR_EN.
module mux_n_pipe
  import mux_pipe_pkg::*;
#(
  parameter  int WIDTH = 32,
  parameter  int N     = 4,
  localparam int SEL_W = clog2(N)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N*WIDTH-1:0] din,
  input  logic [SEL_W-1:0]   sel,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [WIDTH-1:0]   dout,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               sel_err
);

  logic [WIDTH-1:0] sel_data;

  // Out-of-range selects fall through to channel 0, matching the legacy default arm.
  always_comb begin
    // NOTE: default assignment first keeps this block free of inferred latches.
    sel_data = din[0 +: WIDTH];
    for (int k = 1; k < N; k++) begin
      if (int'(sel) == k) sel_data = din[k*WIDTH +: WIDTH];
    end
  end

  mux_skid_buf #(.WIDTH(WIDTH)) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (sel_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dout      (dout),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

`ifdef MUX_N_PIPE_SEL_ERR_EN
  logic sel_ok;
  logic sel_err_q;

  assign sel_ok = (int'(sel) < N);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_err_q <= 1'b0;
    end else if (in_valid && in_ready && !sel_ok) begin
      sel_err_q <= 1'b1;
    end
  end

  assign sel_err = sel_err_q;
`else
  assign sel_err = 1'b0;
`endif

endmodule

// File: tb/tb_mux_n_pipe.sv
// Directed bench for mux_n_pipe: a 4-channel and a 3-channel instance, checked with immediate asserts.
module tb_mux_n_pipe;

`ifdef MUX_N_PIPE_SEL_ERR_EN
  localparam logic SEL_ERR_EXP = 1'b1;
`else
  localparam logic SEL_ERR_EXP = 1'b0;
`endif

  logic        clk;
  logic        rst_n;

  logic [127:0] din4;
  logic [1:0]   sel4;
  logic         in_valid4, in_ready4, out_valid4, out_ready4, sel_err4;
  logic [31:0]  dout4;

  logic [23:0]  din3;
  logic [1:0]   sel3;
  logic         in_valid3, in_ready3, out_valid3, out_ready3, sel_err3;
  logic [7:0]   dout3;

  int n_vec = 0;
  int n_err = 0;

  mux_n_pipe #(.WIDTH(32), .N(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .din(din4), .sel(sel4), .in_valid(in_valid4),
    .in_ready(in_ready4), .dout(dout4), .out_valid(out_valid4),
    .out_ready(out_ready4), .sel_err(sel_err4)
  );

  mux_n_pipe #(.WIDTH(8), .N(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .din(din3), .sel(sel3), .in_valid(in_valid3),
    .in_ready(in_ready3), .dout(dout3), .out_valid(out_valid3),
    .out_ready(out_ready3), .sel_err(sel_err3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge, then settle so registered outputs are sampled away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    din4 = '0; sel4 = '0; in_valid4 = 1'b0; out_ready4 = 1'b0;
    din3 = '0; sel3 = '0; in_valid3 = 1'b0; out_ready3 = 1'b0;
    tick();
    tick();
    check("rst_out_valid", 32'(out_valid4), 32'd0);
    check("rst_in_ready",  32'(in_ready4),  32'd1);
    check("rst_dout",      dout4,           32'd0);
    check("rst_sel_err4",  32'(sel_err4),   32'd0);
    check("rst_sel_err3",  32'(sel_err3),   32'd0);
    rst_n = 1'b1;

    // Single item, sel=2 -> channel 2 = 3 after one edge
    din4 = {32'd4, 32'd3, 32'd2, 32'd1};
    sel4 = 2'd2; in_valid4 = 1'b1; out_ready4 = 1'b1;
    tick();
    check("first_dout",      dout4,             32'd3);
    check("first_out_valid", 32'(out_valid4),   32'd1);
    check("first_in_ready",  32'(in_ready4),    32'd1);

    // Back-to-back stream sel 0..3 with consumer always ready
    for (int i = 0; i < 4; i++) begin
      sel4 = 2'(i);
      tick();
      check($sformatf("stream_dout_%0d", i), dout4, 32'(i + 1));
      check($sformatf("stream_in_ready_%0d", i), 32'(in_ready4), 32'd1);
    end
    in_valid4 = 1'b0;
    tick();
    check("drain_out_valid", 32'(out_valid4), 32'd0);
    check("drain_dout_held", dout4,           32'd4);

    // Back-pressure: A=20, B=30 fill the buffer, C=40 is offered while full and ignored
    din4 = {32'd40, 32'd30, 32'd20, 32'd10};
    out_ready4 = 1'b0; in_valid4 = 1'b1; sel4 = 2'd1;
    tick();
    check("bp_a_dout",     dout4,           32'd20);
    check("bp_a_in_ready", 32'(in_ready4),  32'd1);
    sel4 = 2'd2;
    tick();
    check("bp_full_in_ready",  32'(in_ready4),  32'd0);
    check("bp_full_out_valid", 32'(out_valid4), 32'd1);
    check("bp_full_dout",      dout4,           32'd20);
    sel4 = 2'd3;
    tick();
    check("bp_ignored_dout",     dout4,          32'd20);
    check("bp_ignored_in_ready", 32'(in_ready4), 32'd0);
    in_valid4 = 1'b0; out_ready4 = 1'b1;
    tick();
    check("bp_b_dout",      dout4,           32'd30);
    check("bp_b_in_ready",  32'(in_ready4),  32'd1);
    check("bp_b_out_valid", 32'(out_valid4), 32'd1);
    tick();
    check("bp_empty_out_valid", 32'(out_valid4), 32'd0);
    check("bp_empty_dout_held", dout4,           32'd30);

    // N=3: in-range select first, then sel=3 falls back to channel 0
    din3 = {8'h0C, 8'h0B, 8'h0A};
    sel3 = 2'd2; in_valid3 = 1'b1; out_ready3 = 1'b1;
    tick();
    check("n3_sel2_dout",    32'(dout3),    32'h0C);
    check("n3_sel2_sel_err", 32'(sel_err3), 32'd0);
    sel3 = 2'd3;
    tick();
    check("n3_sel3_dout",      32'(dout3),      32'h0A);
    check("n3_sel3_out_valid", 32'(out_valid3), 32'd1);
    check("n3_sel3_sel_err",   32'(sel_err3),   32'(SEL_ERR_EXP));
    sel3 = 2'd1; in_valid3 = 1'b0;
    tick();
    check("n3_sticky_sel_err", 32'(sel_err3),   32'(SEL_ERR_EXP));
    check("n3_idle_out_valid", 32'(out_valid3), 32'd0);
    check("n3_other_sel_err",  32'(sel_err4),   32'd0);

    // Fill dut4 to FULL, then pulse reset between edges
    out_ready4 = 1'b0; in_valid4 = 1'b1; sel4 = 2'd0;
    tick();
    sel4 = 2'd1;
    tick();
    check("rst6_full_in_ready", 32'(in_ready4), 32'd0);
    in_valid4 = 1'b0;
    rst_n = 1'b0;
    #1;
    check("rst6_async_out_valid", 32'(out_valid4), 32'd0);
    check("rst6_async_in_ready",  32'(in_ready4),  32'd1);
    check("rst6_async_sel_err3",  32'(sel_err3),   32'd0);
    tick();
    rst_n = 1'b1;
    out_ready4 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("rst6_no_emit_%0d", i), 32'(out_valid4), 32'd0);
    end
    check("rst6_dout_cleared", dout4, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
